// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types, including the branch predictor's update bundle,
// its 2-bit counter encoding and the fetch-stage passed values.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int BP_BHR_WIDTH = 2;

  typedef enum logic [1:0] {
    strongly_nt = 2'b00,
    weakly_nt   = 2'b01,
    weakly_t    = 2'b10,
    strongly_t  = 2'b11
  } lc3b_bp_counter;

  typedef struct packed {
    lc3b_word                pc;
    logic                    taken;
    lc3b_word                target;
    logic [BP_BHR_WIDTH-1:0] bhr;
    logic                    mispredict;
  } lc3b_bp_update;

  typedef struct packed {
    lc3b_word                pc;
    logic [BP_BHR_WIDTH-1:0] bhr_out;
    logic                    branch_pred;
    logic                    branch_hit;
    lc3b_word                branch_pred_target;
  } lc3b_passed_vals;

  // Saturating 2-bit counter step.
  function automatic lc3b_bp_counter bp_counter_next(lc3b_bp_counter c, logic taken);
    lc3b_bp_counter n;
    n = c;
    case (c)
      strongly_nt: n = taken ? weakly_nt  : strongly_nt;
      weakly_nt:   n = taken ? weakly_t   : strongly_nt;
      weakly_t:    n = taken ? strongly_t : weakly_nt;
      strongly_t:  n = taken ? strongly_t : weakly_t;
      default:     n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write.
// Only the valid bits are reset; tag/target contents are don't-care while invalid.
module branch_target_buffer
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:1] rd_pc,
  output logic        rd_hit,
  output lc3b_word    rd_target,
  input  logic        wr_en,
  input  logic [15:1] wr_pc,
  input  lc3b_word    wr_target
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 15 - IDX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  lc3b_word            targets [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx, wr_idx;

  assign rd_idx    = rd_pc[IDX_BITS:1];
  assign wr_idx    = wr_pc[IDX_BITS:1];
  assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_pc[15:IDX_BITS+1]);
  assign rd_target = targets[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid         <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]    <= wr_pc[15:IDX_BITS+1];
      targets[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor plus BTB for the fetch stage. Lookup is
// combinational; training and history repair happen on the clock edge.
module branch_predictor
  import lc3b_types::*;
#(
  parameter int BHR_WIDTH    = 2,
  parameter int PHT_BITS     = 4,
  parameter int BTB_IDX_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          fetch_pc,
  input  logic                 fetch_valid,
  input  logic                 stall,
  output logic                 pred_taken,
  output logic [15:0]          pred_target,
  output logic                 btb_hit,
  output logic [BHR_WIDTH-1:0] bhr_out,
  output logic [1:0]           pht_state,
  input  logic                 upd_valid,
  input  logic [15:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [15:0]          upd_target,
  input  logic [BHR_WIDTH-1:0] upd_bhr,
  input  logic                 upd_mispredict
);

  localparam int PHT_ENTRIES = 1 << PHT_BITS;

  // Dropping the top bit of {h,t} gives the shift for any width, including 1.
  function automatic logic [BHR_WIDTH-1:0] shift_hist(logic [BHR_WIDTH-1:0] h, logic t);
    return BHR_WIDTH'({h, t});
  endfunction

  logic [BHR_WIDTH-1:0] spec_bhr, arch_bhr;
  lc3b_bp_counter       pht [PHT_ENTRIES];
  logic [PHT_BITS-1:0]  fetch_idx, upd_idx;
  lc3b_word             btb_target;

  assign fetch_idx = fetch_pc[PHT_BITS:1] ^ PHT_BITS'(spec_bhr);
  assign upd_idx   = upd_pc[PHT_BITS:1] ^ PHT_BITS'(upd_bhr);

  branch_target_buffer #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc[15:1]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (upd_valid && upd_taken),
    .wr_pc     (upd_pc[15:1]),
    .wr_target (upd_target)
  );

  assign pht_state   = pht[fetch_idx];
  assign pred_taken  = btb_hit && pht_state[1];
  assign pred_target = pred_taken ? btb_target : fetch_pc + 16'd2;
  assign bhr_out     = spec_bhr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= weakly_nt;
    end else if (upd_valid) begin
      pht[upd_idx] <= bp_counter_next(pht[upd_idx], upd_taken);
    end
  end

  // Mispredict repair wins over the speculative shift in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_bhr <= '0;
      arch_bhr <= '0;
    end else begin
      if (upd_valid) arch_bhr <= shift_hist(arch_bhr, upd_taken);
      if (upd_valid && upd_mispredict)
        spec_bhr <= shift_hist(upd_bhr, upd_taken);
      else if (fetch_valid && !stall && btb_hit)
        spec_bhr <= shift_hist(spec_bhr, pred_taken);
    end
  end

  // PC bit 0 is always zero for LC-3b instructions; arch_bhr is kept for debug visibility.
  logic unused_ok;
  assign unused_ok = ^{fetch_pc[0], upd_pc[0], arch_bhr};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test-plan steps followed by randomized traffic, all checked against
// an array-based reference model of the predictor rules.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        fetch_valid, stall;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        btb_hit;
  logic [1:0]  bhr_out;
  logic [1:0]  pht_state;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic [1:0]  upd_bhr;
  logic        upd_mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (default parameters: 4-entry history space, 16 PHT, 8 BTB).
  int          m_pht [16];
  bit          m_v   [8];
  int          m_tag [8];
  logic [15:0] m_tgt [8];
  int          m_spec;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .stall(stall),
    .pred_taken(pred_taken), .pred_target(pred_target), .btb_hit(btb_hit),
    .bhr_out(bhr_out), .pht_state(pht_state), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_bhr(upd_bhr),
    .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_spec = 0;
  endtask

  // Expected lookup results for the current fetch_pc under the model state.
  task automatic model_lookup(output bit hit, output int cnt, output bit pred,
                              output logic [15:0] tgt);
    int bi, pi;
    bi   = (int'(fetch_pc) / 2) % 8;
    pi   = ((int'(fetch_pc) / 2) % 16) ^ m_spec;
    hit  = m_v[bi] && (m_tag[bi] == int'(fetch_pc) / 16);
    cnt  = m_pht[pi];
    pred = hit && (cnt >= 2);
    tgt  = pred ? m_tgt[bi] : 16'(fetch_pc + 16'd2);
  endtask

  task automatic check_outputs(input string tag);
    bit hit, pred;
    int cnt;
    logic [15:0] tgt;
    model_lookup(hit, cnt, pred, tgt);
    chk({tag, ".hit"},    16'(btb_hit),    16'(hit));
    chk({tag, ".taken"},  16'(pred_taken), 16'(pred));
    chk({tag, ".target"}, pred_target,     tgt);
    chk({tag, ".bhr"},    16'(bhr_out),    16'(m_spec));
    chk({tag, ".pht"},    16'(pht_state),  16'(cnt));
  endtask

  // Called just after a negedge: drive, check lookup, clock once, advance model.
  task automatic step(input string tag, input logic fv, input logic st, input logic [15:0] pc,
                      input logic uv, input logic [15:0] upc, input logic ut,
                      input logic [15:0] utgt, input logic [1:0] ubhr, input logic umis);
    bit hit, pred;
    int cnt, ui, bi, nspec;
    logic [15:0] tgt;
    fetch_valid = fv; stall = st; fetch_pc = pc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_bhr = ubhr; upd_mispredict = umis;
    #1;
    check_outputs(tag);
    model_lookup(hit, cnt, pred, tgt);
    nspec = m_spec;
    if (uv && umis)          nspec = ((int'(ubhr) * 2) + int'(ut)) % 4;
    else if (fv && !st && hit) nspec = ((m_spec * 2) + int'(pred)) % 4;
    @(posedge clk);
    if (uv) begin
      ui = ((int'(upc) / 2) % 16) ^ int'(ubhr);
      m_pht[ui] = ut ? ((m_pht[ui] < 3) ? m_pht[ui] + 1 : 3)
                     : ((m_pht[ui] > 0) ? m_pht[ui] - 1 : 0);
      if (ut) begin
        bi = (int'(upc) / 2) % 8;
        m_v[bi] = 1; m_tag[bi] = int'(upc) / 16; m_tgt[bi] = utgt;
      end
    end
    m_spec = nspec;
    @(negedge clk);
  endtask

  task automatic idle_fetch(input string tag, input logic [15:0] pc);
    step(tag, 1'b0, 1'b0, pc, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 16'h0040; fetch_valid = 0; stall = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_bhr = 0; upd_mispredict = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    #1;
    chk("rst.hit", 16'(btb_hit), 16'd0);
    chk("rst.taken", 16'(pred_taken), 16'd0);
    chk("rst.target", pred_target, 16'h0042);
    chk("rst.bhr", 16'(bhr_out), 16'd0);
    chk("rst.pht", 16'(pht_state), 16'd1);
    @(negedge clk);

    // 2: train 0x0040 -> 0x0060 three times
    repeat (3) step("train", 1'b0, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0060, 2'b00, 1'b0);
    fetch_pc = 16'h0040; #1;
    chk("trained.hit", 16'(btb_hit), 16'd1);
    chk("trained.pht", 16'(pht_state), 16'd3);
    chk("trained.taken", 16'(pred_taken), 16'd1);
    chk("trained.target", pred_target, 16'h0060);

    // 3: same index, different tag
    fetch_pc = 16'h0050; #1;
    chk("alias.hit", 16'(btb_hit), 16'd0);
    chk("alias.taken", 16'(pred_taken), 16'd0);
    chk("alias.target", pred_target, 16'h0052);
    @(negedge clk);

    // 4: speculative shift, then stall holds it
    step("spec", 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 1'b0);
    #1 chk("spec.bhr", 16'(bhr_out), 16'd1);
    step("stall", 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 1'b0);
    #1 chk("stall.bhr", 16'(bhr_out), 16'd1);

    // 5: mispredict repair overrides a hitting fetch in the same cycle
    step("repair", 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0, 2'b10, 1'b1);
    fetch_pc = 16'h0004; fetch_valid = 0; upd_valid = 0; #1;
    chk("repair.bhr", 16'(bhr_out), 16'd0);
    chk("repair.pht2", 16'(pht_state), 16'd0);
    @(negedge clk);

    // 6: asynchronous reset between edges
    fetch_pc = 16'h0040; #1;
    chk("prerst.hit", 16'(btb_hit), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst.hit", 16'(btb_hit), 16'd0);
    chk("arst.target", pred_target, 16'h0042);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) idle_fetch("arst.scan", 16'(i * 2));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] pc, upc;
      pc  = 16'($urandom_range(0, 31) * 2) | ($urandom_range(0, 1) ? 16'h0100 : 16'h0000);
      upc = 16'($urandom_range(0, 31) * 2) | ($urandom_range(0, 1) ? 16'h0100 : 16'h0000);
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), pc,
           1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 32767) * 2), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised gshare direction predictor plus direct-mapped branch target buffer (BTB) for the LC-3b pipeline fetch stage.
- Lookup is combinational on the fetch PC. Its outputs fill the bhr_out, branch_pred, branch_hit and branch_pred_target fields of lc3b_passed_vals.
- Resolved branches from the execute/mem stage train the predictor synchronously.
- A speculative global history register (BHR) is repaired on mispredict.

Parameters:
BHR_WIDTH, 2, global history bits; 1 <= BHR_WIDTH <= PHT_BITS
PHT_BITS, 4, log2 of pattern history table entries (2-bit counters)
BTB_IDX_BITS, 3, log2 of BTB entries; tag width = 15 - BTB_IDX_BITS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_pc  in  16  PC being fetched
fetch_valid  in  1  fetch PC valid this cycle
stall  in  1  fetch stalled; no speculative history shift
pred_taken  out  1  predicted taken
pred_target  out  16  next-PC prediction
btb_hit  out  1  valid BTB entry with matching tag
bhr_out  out  BHR_WIDTH  speculative BHR snapshot used for this lookup
pht_state  out  2  counter value read for this lookup
upd_valid  in  1  resolved branch this cycle
upd_pc  in  16  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  16  actual taken target
upd_bhr  in  BHR_WIDTH  BHR snapshot carried with the branch
upd_mispredict  in  1  direction or target was mispredicted

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high.
- Reset state:
  - all BTB valid bits 0
  - all PHT counters 2'b01 (weakly not-taken)
  - spec_bhr = 0, arch_bhr = 0
- Outputs are combinational. Immediately after reset: btb_hit=0, pred_taken=0, pred_target=fetch_pc+2, bhr_out=0, pht_state=01.
- Lookup (zero latency):
  - BTB index = fetch_pc[BTB_IDX_BITS:1]; tag = fetch_pc[15:BTB_IDX_BITS+1].
  - PHT index = fetch_pc[PHT_BITS:1] XOR zero-extended spec_bhr.
  - btb_hit = valid & tag match.
  - pred_taken = btb_hit & pht[idx][1].
  - pred_target = pred_taken ? btb_target : fetch_pc+2 (16-bit wrap).
  - bhr_out = spec_bhr.
  - pht_state = pht[idx].
- History shift function: shift(h,t) = {h[BHR_WIDTH-2:0], t}. For BHR_WIDTH=1 it is {t}.
- Speculative shift: on a rising edge with fetch_valid & ~stall & btb_hit, spec_bhr <= shift(spec_bhr, pred_taken).
- Update (on rising edge when upd_valid):
  - PHT index = upd_pc[PHT_BITS:1] XOR upd_bhr. The counter saturates: taken increments up to 11, not-taken decrements down to 00.
  - arch_bhr <= shift(arch_bhr, upd_taken).
  - If upd_taken: BTB[upd idx] <= {valid=1, upd tag, upd_target}. If not taken, the BTB is untouched.
  - If upd_mispredict: spec_bhr <= shift(upd_bhr, upd_taken).
- Simultaneous events:
  - Mispredict repair overrides the speculative shift in the same cycle.
  - A lookup and an update to the same entry in the same cycle: the lookup returns the pre-update value (no bypass).
- An update while stall=1 still applies.
- rst asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Additions to lc3b_types:
  - typedef lc3b_bp_update, a packed struct {pc, taken, target, bhr, mispredict}
  - typedef lc3b_bp_counter, an enum strongly_nt=00, weakly_nt=01, weakly_t=10, strongly_t=11
  - bhr_out in lc3b_passed_vals resized to a package localparam BP_BHR_WIDTH
- One sub-module: branch_target_buffer. It holds the parametrised direct-mapped tag/target/valid arrays, with combinational read and synchronous write.

Test Plan:
(Default parameters throughout.)
1. Reset, then fetch_pc=0x0040, fetch_valid=0 -> btb_hit=0, pred_taken=0, pred_target=0x0042, bhr_out=00, pht_state=01.
2. With fetch_valid=0, three updates upd_pc=0x0040, taken=1, target=0x0060, upd_bhr=00, mispredict=0 (pht[0]: 01→10→11→11). Then fetch 0x0040 -> btb_hit=1, pht_state=11, pred_taken=1, pred_target=0x0060.
3. After scenario 2, fetch_pc=0x0050 (same BTB index 0, tag 0x005 ≠ 0x004) -> btb_hit=0, pred_taken=0, pred_target=0x0052.
4. After scenario 2, hold fetch_pc=0x0040, fetch_valid=1, stall=0 for 1 cycle -> spec_bhr=01. Repeat with stall=1 -> spec_bhr stays 01.
5. spec_bhr=01. Same cycle: fetch hit (would shift) plus upd_valid, upd_pc=0x0040, upd_bhr=10, taken=0, mispredict=1 -> next cycle bhr_out=00; pht[2] decremented from 01 to 00.
6. Entry trained, rst pulsed high mid-cycle with no clock edge -> btb_hit=0 and pred_target=fetch_pc+2 immediately; after release, all pht_state reads return 01.
